// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Operation encodings follow funct3 of the M-extension instructions.
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int DXLEN = 2 * XLEN;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP,
      S_DONE
   } state_e;

   localparam logic [XLEN-1:0] DIV0_Q = '1;
   localparam logic [XLEN-1:0] OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of either the shift-add multiplier or the restoring divider.
// hi/lo hold {product upper, product lower/multiplier} or {remainder, quotient/dividend}.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next
);

   logic [XLEN:0] addend;
   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // A set top bit of diff means the trial subtraction went negative: restore.
   always_comb begin
      addend  = lo[0] ? {1'b0, opnd} : '0;
      sum     = {1'b0, hi} + addend;
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      if (is_div) begin
         if (diff[XLEN]) begin
            hi_next = shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b0};
         end else begin
            hi_next = diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_next = sum[XLEN:1];
         lo_next = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit with a start/busy/done handshake.
// Works on operand magnitudes; signs are restored in the FIXUP cycle.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_e           state, state_next;
   op_e              op_in, op_q;
   logic [XLEN-1:0]  hi, lo, opnd, hi_step, lo_step;
   logic             sign_a, sign_b;
   logic [CNT_W-1:0] counter;

   logic             is_div_in, a_signed, b_signed, sa_in, sb_in;
   logic             special, accept, load_result;
   logic [XLEN-1:0]  mag_a, mag_b, special_res, fixup_res, res_next;
   logic [DXLEN-1:0] product;
   logic [XLEN-1:0]  quotient, remainder;

   assign op_in = op_e'(op);

   muldiv_step u_step (
      .is_div  (op_q[2]),
      .hi      (hi),
      .lo      (lo),
      .opnd    (opnd),
      .hi_next (hi_step),
      .lo_next (lo_step)
   );

   // Operand decode; divide-by-zero and signed overflow bypass the iterations.
   always_comb begin
      is_div_in   = op[2];
      a_signed    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
      b_signed    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
      sa_in       = a_signed & a[XLEN-1];
      sb_in       = b_signed & b[XLEN-1];
      mag_a       = negate_if(sa_in, a);
      mag_b       = negate_if(sb_in, b);
      special     = 1'b0;
      special_res = '0;
      if (is_div_in && (b == '0)) begin
         special     = 1'b1;
         special_res = op[1] ? a : DIV0_Q;
      end else if (is_div_in && b_signed && (a == OVF_Q) && (b == '1)) begin
         special     = 1'b1;
         special_res = op[1] ? '0 : OVF_Q;
      end
   end

   always_comb begin
      product = {hi, lo};
      if (sign_a ^ sign_b) begin
         product = -product;
      end
      quotient  = negate_if(sign_a ^ sign_b, lo);
      remainder = negate_if(sign_a, hi);
      case (op_q)
         OP_MUL:                        fixup_res = product[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fixup_res = product[DXLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fixup_res = quotient;
         default:                       fixup_res = remainder;
      endcase
      res_next = (state == S_IDLE) ? special_res : fixup_res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // kill wins over start and suppresses the result write of an unfinished op.
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;
      load_result = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !kill) begin
               accept = 1'b1;
               if (special) begin
                  state_next  = S_DONE;
                  load_result = 1'b1;
               end else begin
                  state_next = S_CALC;
               end
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (kill) begin
               state_next = S_IDLE;
            end else if (counter == CNT_W'(XLEN - 1)) begin
               state_next = S_FIXUP;
            end
         end
         S_FIXUP: begin
            busy = 1'b1;
            if (kill) begin
               state_next = S_IDLE;
            end else begin
               state_next  = S_DONE;
               load_result = 1'b1;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= OP_MUL;
         hi      <= '0;
         lo      <= '0;
         opnd    <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         counter <= '0;
         result  <= '0;
      end else begin
         if (accept) begin
            op_q    <= op_in;
            hi      <= '0;
            lo      <= is_div_in ? mag_a : mag_b;
            opnd    <= is_div_in ? mag_b : mag_a;
            sign_a  <= sa_in;
            sign_b  <= sb_in;
            counter <= '0;
         end else if (state == S_CALC) begin
            hi      <= hi_step;
            lo      <= lo_step;
            counter <= counter + CNT_W'(1);
         end
         if (load_result) begin
            result <= res_next;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, kill, reset and handshake.
// Cycle 1 is the first cycle after the edge that accepts start.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        kill  = 1'b0;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy, done;
   logic [31:0] result;

   int          compared   = 0;
   int          mismatched = 0;
   int          done_count = 0;
   int          done_cyc, busy_cnt, snap;
   logic [31:0] res;

   muldiv_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .kill   (kill),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_count++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Called between edges; returns #1 after the accept edge (cycle 1).
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int first_cyc, output int dcyc, output logic [31:0] r, output int bcnt);
      dcyc = -1;
      bcnt = 0;
      r    = 'x;
      for (int c = first_cyc; c <= 40; c++) begin
         if (c > first_cyc) begin
            @(posedge clk);
            #1;
         end
         if (busy) bcnt++;
         if (done) begin
            dcyc = c;
            r    = result;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int dcyc, output logic [31:0] r, output int bcnt);
      applyStimulus(o, x, y);
      wait_done(1, dcyc, r, bcnt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      checkOutput("reset_busy",   32'(busy),   32'd0);
      checkOutput("reset_done",   32'(done),   32'd0);
      checkOutput("reset_result", result,      32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, done_cyc, res, busy_cnt);
      checkOutput("mul_result",  res,           32'hFFFF_FFEB);
      checkOutput("mul_latency", 32'(done_cyc), 32'd34);
      checkOutput("mul_busy",    32'(busy_cnt), 32'd33);

      run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, done_cyc, res, busy_cnt);
      checkOutput("mulh_result", res, 32'h4000_0000);
      run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, done_cyc, res, busy_cnt);
      checkOutput("mulhu_result", res, 32'hFFFF_FFFE);
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, done_cyc, res, busy_cnt);
      checkOutput("mulhsu_result", res, 32'hFFFF_FFFF);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, done_cyc, res, busy_cnt);
      checkOutput("div_result",  res,           32'hFFFF_FFFD);
      checkOutput("div_latency", 32'(done_cyc), 32'd34);
      run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, done_cyc, res, busy_cnt);
      checkOutput("rem_result", res, 32'hFFFF_FFFF);
      run_op(OP_DIVU, 32'd100, 32'd7, done_cyc, res, busy_cnt);
      checkOutput("divu_result", res, 32'd14);
      run_op(OP_REMU, 32'd100, 32'd7, done_cyc, res, busy_cnt);
      checkOutput("remu_result", res, 32'd2);

      run_op(OP_DIVU, 32'd100, 32'd0, done_cyc, res, busy_cnt);
      checkOutput("divu0_result",  res,           32'hFFFF_FFFF);
      checkOutput("divu0_latency", 32'(done_cyc), 32'd1);
      checkOutput("divu0_busy",    32'(busy_cnt), 32'd0);
      run_op(OP_REM, 32'd100, 32'd0, done_cyc, res, busy_cnt);
      checkOutput("rem0_result", res, 32'd100);
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, done_cyc, res, busy_cnt);
      checkOutput("removf_result", res, 32'h0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, done_cyc, res, busy_cnt);
      checkOutput("divovf_result",  res,           32'h8000_0000);
      checkOutput("divovf_latency", 32'(done_cyc), 32'd1);

      // Flush an in-flight multiply at cycle 10, then restart at cycle 12.
      snap = done_count;
      applyStimulus(OP_MUL, 32'd3, 32'd5);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      checkOutput("kill_busy",   32'(busy), 32'd0);
      checkOutput("kill_result", result,    32'h8000_0000);
      @(posedge clk);
      #1;
      checkOutput("kill_no_done", 32'(done_count), 32'(snap));
      run_op(OP_MUL, 32'd3, 32'd5, done_cyc, res, busy_cnt);
      checkOutput("after_kill_result",  res,           32'd15);
      checkOutput("after_kill_latency", 32'(done_cyc), 32'd34);

      // kill together with start in IDLE must not start an operation.
      start = 1'b1;
      kill  = 1'b1;
      op    = OP_DIVU;
      a     = 32'd9;
      b     = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      kill  = 1'b0;
      checkOutput("kill_start_done", 32'(done), 32'd0);
      checkOutput("kill_start_result", result, 32'd15);

      // A start during the DONE cycle is ignored.
      applyStimulus(OP_DIVU, 32'd100, 32'd0);
      checkOutput("done_cycle_done", 32'(done), 32'd1);
      start = 1'b1;
      op    = OP_MUL;
      a     = 32'd2;
      b     = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("done_start_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("done_start_no_done", 32'(done), 32'd0);
      checkOutput("done_start_result", result, 32'hFFFF_FFFF);

      // A second start at cycle 5 of a divide is ignored.
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      op    = OP_MUL;
      a     = 32'd2;
      b     = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(6, done_cyc, res, busy_cnt);
      checkOutput("busy_start_result",  res,           32'd14);
      checkOutput("busy_start_latency", 32'(done_cyc), 32'd34);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a divide.
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy",   32'(busy), 32'd0);
      checkOutput("midreset_done",   32'(done), 32'd0);
      checkOutput("midreset_result", result,    32'h0);
      snap = done_count;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      checkOutput("midreset_no_done", 32'(done_count), 32'(snap));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
